// File: rtl/md_unit_if.sv
// Operand/command and result bundle between the MIPS datapath and the
// multiply/divide unit.
interface md_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit holding the architectural HI/LO pair;
// results are computed on accept and committed when the busy window closes.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] hi_r, lo_r, hi_nxt, lo_nxt;
  logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic        pend_wr, pend_wr_nxt;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, is_sdiv;
  logic [31:0] dvd, dvs, uq, ur, quo, rem;

  assign prod_s = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
  assign prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};

  // One unsigned divider serves both DIV and DIVU; signed division works on
  // magnitudes and fixes signs afterwards, which also makes MIN/-1 wrap cleanly.
  assign a_neg   = md.src_a[31];
  assign b_neg   = md.src_b[31];
  assign is_sdiv = (md.md_op == OP_DIV);
  assign dvd     = (is_sdiv && a_neg) ? (32'd0 - md.src_a) : md.src_a;
  assign dvs     = (md.src_b == 32'd0) ? 32'd1
                 : ((is_sdiv && b_neg) ? (32'd0 - md.src_b) : md.src_b);
  assign uq      = dvd / dvs;
  assign ur      = dvd % dvs;
  assign quo     = (is_sdiv && (a_neg ^ b_neg)) ? (32'd0 - uq) : uq;
  assign rem     = (is_sdiv && a_neg) ? (32'd0 - ur) : ur;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_r;
    lo_nxt      = lo_r;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_wr_nxt = pend_wr;
    case (state)
      IDLE: begin
        if (md.start) begin
          case (md.md_op)
            OP_MULT: begin
              pend_hi_nxt = prod_s[63:32];
              pend_lo_nxt = prod_s[31:0];
              pend_wr_nxt = 1'b1;
              cnt_nxt     = CW'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_MULTU: begin
              pend_hi_nxt = prod_u[63:32];
              pend_lo_nxt = prod_u[31:0];
              pend_wr_nxt = 1'b1;
              cnt_nxt     = CW'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_nxt = rem;
              pend_lo_nxt = quo;
              pend_wr_nxt = (md.src_b != 32'd0);
              cnt_nxt     = CW'(DIV_CYCLES);
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = md.src_a;
            OP_MTLO: lo_nxt = md.src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt   = IDLE;
          pend_wr_nxt = 1'b0;
          if (pend_wr) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_r    <= hi_nxt;
      lo_r    <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_wr <= pend_wr_nxt;
    end
  end

  assign md.busy = (state == RUN);
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

  always_comb begin
    md.rd_data = '0;
    case (md.md_op)
      OP_MFHI: md.rd_data = hi_r;
      OP_MFLO: md.rd_data = lo_r;
      default: md.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n;

  md_unit_if md();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; holds the command across one posedge
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1;
    md.md_op = op;
    md.src_a = a;
    md.src_b = b;
    @(negedge clk);
    md.start = 1'b0;
    md.md_op = 4'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (md.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    start_op(op, a, b);
    chk({tag, "_busy0"}, md.busy, 1'b1);
    chk({tag, "_hold"}, {md.hi, md.lo}, {old_hi, old_lo});
    wait_idle(c);
    chk({tag, "_cycles"}, c, ncyc);
    chk({tag, "_hi"}, md.hi, exp_hi);
    chk({tag, "_lo"}, md.lo, exp_lo);
  endtask

  initial begin
    reset    = 1'b1;
    md.start = 1'b0;
    md.md_op = 4'd0;
    md.src_a = '0;
    md.src_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", md.busy, 1'b0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);
    md.md_op = 4'd7; #1;
    chk("rst_mfhi", md.rd_data, 32'd0);
    md.md_op = 4'd0;
    @(negedge clk);

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h1, 32'hFFFFFFFE);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 32'h80000000);
    run_op("divu",  4'd4, 32'd100, 32'd7, 10, 32'h0, 32'h80000000, 32'd2, 32'd14);
    run_op("divneg", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd2, 32'd14, 32'd1, 32'hFFFFFFFD);

    // MTHI then MFHI / MFLO / undefined op readback
    start_op(4'd5, 32'h12345678, 32'd0);
    chk("mthi_busy", md.busy, 1'b0);
    chk("mthi_hi", md.hi, 32'h12345678);
    md.md_op = 4'd7; #1;
    chk("mfhi_rd", md.rd_data, 32'h12345678);
    md.md_op = 4'd8; #1;
    chk("mflo_rd", md.rd_data, 32'hFFFFFFFD);
    md.md_op = 4'd12; #1;
    chk("op12_rd", md.rd_data, 32'd0);
    @(negedge clk);
    md.md_op = 4'd0;

    // MTLO while busy is dropped
    start_op(4'd2, 32'd3, 32'd4);
    start_op(4'd6, 32'hDEADBEEF, 32'd0);
    chk("mtlo_busy_lo", md.lo, 32'hFFFFFFFD);
    wait_idle(n);
    chk("mtlo_busy_cyc", n, 4);
    chk("mtlo_busy_res", {md.hi, md.lo}, {32'd0, 32'd12});

    // second MULT during busy is ignored
    start_op(4'd1, 32'd5, 32'd6);
    @(negedge clk);
    start_op(4'd1, 32'd100, 32'd100);
    wait_idle(n);
    chk("mult2_cyc", n, 3);
    chk("mult2_res", {md.hi, md.lo}, {32'd0, 32'd30});
    repeat (6) @(negedge clk);
    chk("mult2_late", {md.busy, md.hi, md.lo}, {1'b0, 32'd0, 32'd30});

    // reset mid-divide aborts with no late commit
    start_op(4'd3, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid", {md.busy, md.hi, md.lo}, {1'b0, 32'd0, 32'd0});
    repeat (15) @(negedge clk);
    chk("rst_late", {md.busy, md.hi, md.lo}, {1'b0, 32'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
